// File: rtl/ex_mem_wb_pipe.sv
// ex_mem_wb_pipe: EX->MEM->WB pipeline registers with a two-state data-memory
// access FSM (IDLE/ACCESS), load-use stall detection and WB write-back.
// Optional feature macro: MEM_TIMEOUT_EN adds an ACCESS watchdog of
// TIMEOUT_CYCLES cycles that drops the stuck op and sets the sticky mem_error.
//
// Memory handshake: mem_req is held high for the whole ACCESS state with
// mem_we/mem_addr/mem_wdata stable; the transfer completes on the rising edge
// where mem_req=1 and mem_ack=1 are both sampled. mem_ack outside ACCESS is
// ignored.
module ex_mem_wb_pipe #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_EX,
  input  logic [3:0]  op_type_EX,
  input  logic [31:0] alu_result_EX,
  input  logic [31:0] store_data_EX,
  input  logic        reg_write_enable_EX,
  input  logic [4:0]  reg_write_address_EX,
  input  logic [4:0]  read_register_1_EX,
  input  logic [4:0]  read_register_2_EX,
  output logic        reg_write_enable_MEM,
  output logic [4:0]  reg_write_address_MEM,
  output logic [31:0] alu_result_MEM,
  output logic        reg_write_enable_WB,
  output logic [4:0]  reg_write_address_WB,
  output logic [31:0] reg_write_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_EX,
  output logic        mem_error,
  output logic        dbg_state
);

  localparam logic [3:0] OP_LW  = 4'b0110;
  localparam logic [3:0] OP_SW  = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_J   = 4'b1001;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [0:0]  state_q, state_d;
  logic [3:0]  mem_op_q, mem_op_d;
  logic [31:0] mem_alu_q, mem_alu_d;
  logic [31:0] mem_sdata_q, mem_sdata_d;
  logic        mem_wen_q, mem_wen_d;
  logic [4:0]  mem_waddr_q, mem_waddr_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic in_access;
  logic mem_is_lw;
  logic ex_is_mem;
  logic load_use;
  logic capture;
  logic timeout_hit;

  assign in_access = (state_q == S_ACCESS);
  assign mem_is_lw = (mem_op_q == OP_LW);
  assign ex_is_mem = valid_EX && ((op_type_EX == OP_LW) || (op_type_EX == OP_SW));

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          mem_error_q, mem_error_d;

  // Watchdog: count unacknowledged ACCESS cycles, fire on the last allowed one.
  always_comb begin
    timeout_hit = in_access && !mem_ack && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
    tmo_cnt_d   = (in_access && !mem_ack && !timeout_hit) ? tmo_cnt_q + 1'b1 : '0;
    mem_error_d = mem_error_q || timeout_hit;
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q   <= '0;
      mem_error_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign mem_error = mem_error_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_error   = 1'b0;
`endif

  // Hazard detection: the LW stops blocking its consumer on the ack clock.
  always_comb begin
    load_use = mem_is_lw && (mem_waddr_q != 5'd0) && valid_EX &&
               ((mem_waddr_q == read_register_1_EX) || (mem_waddr_q == read_register_2_EX)) &&
               !(in_access && mem_ack);
    stall_EX = (in_access && !mem_ack) || load_use;
    capture  = !stall_EX;
  end

  // Next-state for the FSM, the MEM register and the WB register.
  always_comb begin
    state_d     = state_q;
    mem_op_d    = mem_op_q;
    mem_alu_d   = mem_alu_q;
    mem_sdata_d = mem_sdata_q;
    mem_wen_d   = mem_wen_q;
    mem_waddr_d = mem_waddr_q;
    wb_en_d     = 1'b0;
    wb_addr_d   = 5'd0;
    wb_data_d   = 32'd0;

    // FSM: leave ACCESS on ack/timeout; a newly captured memory op re-enters it.
    if (in_access && (mem_ack || timeout_hit)) state_d = S_IDLE;
    if (capture && ex_is_mem)                  state_d = S_ACCESS;

    // MEM register: capture EX (bubble when invalid), or drop a timed-out op.
    if (capture) begin
      mem_op_d    = valid_EX ? op_type_EX : 4'd0;
      mem_alu_d   = valid_EX ? alu_result_EX : 32'd0;
      mem_sdata_d = valid_EX ? store_data_EX : 32'd0;
      mem_waddr_d = valid_EX ? reg_write_address_EX : 5'd0;
      mem_wen_d   = valid_EX && reg_write_enable_EX && (reg_write_address_EX != 5'd0) &&
                    (op_type_EX != OP_SW) && (op_type_EX != OP_BEQ) && (op_type_EX != OP_J);
    end else if (timeout_hit) begin
      mem_op_d    = 4'd0;
      mem_alu_d   = 32'd0;
      mem_sdata_d = 32'd0;
      mem_waddr_d = 5'd0;
      mem_wen_d   = 1'b0;
    end

    // WB register: memory result on ack, bubble while waiting, else MEM passes.
    if (in_access) begin
      if (mem_ack) begin
        wb_en_d   = mem_is_lw && mem_wen_q;
        wb_addr_d = mem_waddr_q;
        wb_data_d = mem_rdata;
      end
    end else begin
      wb_en_d   = mem_wen_q;
      wb_addr_d = mem_waddr_q;
      wb_data_d = mem_alu_q;
    end
  end

  // Pipeline and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_op_q    <= 4'd0;
      mem_alu_q   <= 32'd0;
      mem_sdata_q <= 32'd0;
      mem_wen_q   <= 1'b0;
      mem_waddr_q <= 5'd0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      mem_op_q    <= mem_op_d;
      mem_alu_q   <= mem_alu_d;
      mem_sdata_q <= mem_sdata_d;
      mem_wen_q   <= mem_wen_d;
      mem_waddr_q <= mem_waddr_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
    end
  end

  // A loaded address is never offered as forwardable data.
  assign reg_write_enable_MEM  = mem_wen_q && !mem_is_lw;
  assign reg_write_address_MEM = mem_waddr_q;
  assign alu_result_MEM        = mem_alu_q;
  assign reg_write_enable_WB   = wb_en_q;
  assign reg_write_address_WB  = wb_addr_q;
  assign reg_write_data        = wb_data_q;
  assign mem_req               = in_access;
  assign mem_we                = in_access && (mem_op_q == OP_SW);
  assign mem_addr              = mem_alu_q;
  assign mem_wdata             = mem_sdata_q;
  assign dbg_state             = state_q;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Testbench for ex_mem_wb_pipe: directed instruction stream, memory responder
// with configurable ack latency, and scoreboards for WB writes and memory ops.
module tb_ex_mem_wb_pipe;

  localparam int TMO = 16;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0110;
  localparam logic [3:0] OP_SW  = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_J   = 4'b1001;

  logic        clk;
  logic        rst_n;
  logic        valid_EX;
  logic [3:0]  op_type_EX;
  logic [31:0] alu_result_EX;
  logic [31:0] store_data_EX;
  logic        reg_write_enable_EX;
  logic [4:0]  reg_write_address_EX;
  logic [4:0]  read_register_1_EX;
  logic [4:0]  read_register_2_EX;
  logic        reg_write_enable_MEM;
  logic [4:0]  reg_write_address_MEM;
  logic [31:0] alu_result_MEM;
  logic        reg_write_enable_WB;
  logic [4:0]  reg_write_address_WB;
  logic [31:0] reg_write_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_EX;
  logic        mem_error;
  logic        dbg_state;

  ex_mem_wb_pipe #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_EX(valid_EX), .op_type_EX(op_type_EX),
    .alu_result_EX(alu_result_EX), .store_data_EX(store_data_EX),
    .reg_write_enable_EX(reg_write_enable_EX), .reg_write_address_EX(reg_write_address_EX),
    .read_register_1_EX(read_register_1_EX), .read_register_2_EX(read_register_2_EX),
    .reg_write_enable_MEM(reg_write_enable_MEM), .reg_write_address_MEM(reg_write_address_MEM),
    .alu_result_MEM(alu_result_MEM), .reg_write_enable_WB(reg_write_enable_WB),
    .reg_write_address_WB(reg_write_address_WB), .reg_write_data(reg_write_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_EX(stall_EX),
    .mem_error(mem_error), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [36:0] exp_wb_q[$];   // {addr, data}
  logic [64:0] exp_mem_q[$];  // {we, addr, wdata}

  int          ack_lat = 1;
  bit          no_ack = 1'b0;
  logic [31:0] rd_val = 32'd0;
  int          wait_cnt = 0;
  int          stall_cnt = 0;
  int          req_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder + memory scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n || !mem_req || no_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= ack_lat - 1) begin
      mem_ack   = 1'b1;
      mem_rdata = rd_val;
      wait_cnt  = 0;
      if (exp_mem_q.size() == 0) begin
        check("mem_unexpected_access", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [64:0] e;
        e = exp_mem_q.pop_front();
        check("mem_we", 64'(mem_we), 64'(e[64]));
        check("mem_addr", 64'(mem_addr), 64'(e[63:32]));
        check("mem_wdata", 64'(mem_wdata), 64'(e[31:0]));
      end
    end else begin
      mem_ack = 1'b0;
      wait_cnt++;
    end
  end

  // ---------------- WB scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && reg_write_enable_WB) begin
      if (exp_wb_q.size() == 0) begin
        check("wb_unexpected_write", 64'({reg_write_address_WB, reg_write_data}), 64'h0);
      end else begin
        logic [36:0] e;
        e = exp_wb_q.pop_front();
        check("wb_addr", 64'(reg_write_address_WB), 64'(e[36:32]));
        check("wb_data", 64'(reg_write_data), 64'(e[31:0]));
      end
    end
  end

  // Cycle counters sampled late in each cycle, after the responder settles.
  always begin
    @(negedge clk);
    #4;
    if (stall_EX) stall_cnt++;
    if (mem_req)  req_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic we,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] alu, input logic [31:0] sdata, output int stalls);
    stalls = 0;
    @(negedge clk);
    valid_EX = 1'b1; op_type_EX = op; alu_result_EX = alu; store_data_EX = sdata;
    reg_write_enable_EX = we; reg_write_address_EX = rd;
    read_register_1_EX = rs1; read_register_2_EX = rs2;
    #4;
    while (stall_EX && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #4;
    end
    if (stalls >= 100) check("issue_stall_bound", 64'(stalls), 64'd0);
    @(posedge clk);
    #1;
    valid_EX = 1'b0; op_type_EX = 4'd0; alu_result_EX = 32'd0; store_data_EX = 32'd0;
    reg_write_enable_EX = 1'b0; reg_write_address_EX = 5'd0;
    read_register_1_EX = 5'd0; read_register_2_EX = 5'd0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (dbg_state != 1'b0 && n < bound);
    if (dbg_state != 1'b0) check("wait_idle_bound", 64'(dbg_state), 64'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int st;
    rst_n = 1'b0; valid_EX = 1'b0; op_type_EX = 4'd0; alu_result_EX = 32'd0;
    store_data_EX = 32'd0; reg_write_enable_EX = 1'b0; reg_write_address_EX = 5'd0;
    read_register_1_EX = 5'd0; read_register_2_EX = 5'd0; mem_rdata = 32'd0; mem_ack = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_stage", 64'({reg_write_enable_MEM, reg_write_address_MEM, alu_result_MEM}), 64'd0);
    check("reset_wb_stage", 64'({reg_write_enable_WB, reg_write_address_WB, reg_write_data}), 64'd0);
    check("reset_mem_port", 64'({mem_req, mem_we, mem_addr}), 64'd0);
    check("reset_ctrl", 64'({stall_EX, mem_error, dbg_state}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD r3 = 5: MEM next cycle, WB the cycle after.
    exp_wb_q.push_back({5'd3, 32'h0000_0005});
    issue(OP_ADD, 5'd3, 1'b1, 5'd1, 5'd2, 32'h0000_0005, 32'd0, st);
    check("add_no_stall", 64'(st), 64'd0);
    check("add_mem_stage", 64'({reg_write_enable_MEM, reg_write_address_MEM, alu_result_MEM}),
          64'({1'b1, 5'd3, 32'h0000_0005}));
    @(posedge clk); #1;
    check("add_wb_stage", 64'({reg_write_enable_WB, reg_write_address_WB, reg_write_data}),
          64'({1'b1, 5'd3, 32'h0000_0005}));

    // ADD to r0 never writes.
    issue(OP_ADD, 5'd0, 1'b1, 5'd1, 5'd2, 32'h0000_0099, 32'd0, st);
    check("r0_mem_en", 64'(reg_write_enable_MEM), 64'd0);
    @(posedge clk); #1;
    check("r0_wb_en", 64'(reg_write_enable_WB), 64'd0);

    // BEQ and J with write-enable set still never write.
    issue(OP_BEQ, 5'd9, 1'b1, 5'd1, 5'd2, 32'h0000_0011, 32'd0, st);
    check("beq_mem_en", 64'(reg_write_enable_MEM), 64'd0);
    issue(OP_J, 5'd10, 1'b1, 5'd0, 5'd0, 32'h0000_0022, 32'd0, st);
    check("j_mem_en", 64'(reg_write_enable_MEM), 64'd0);
    @(posedge clk); #1;

    // LW r4 @0x100, ack in 3rd ACCESS cycle.
    ack_lat = 3; rd_val = 32'hDEAD_BEEF;
    exp_mem_q.push_back({1'b0, 32'h0000_0100, 32'd0});
    exp_wb_q.push_back({5'd4, 32'hDEAD_BEEF});
    stall_cnt = 0; req_cnt = 0;
    issue(OP_LW, 5'd4, 1'b1, 5'd1, 5'd0, 32'h0000_0100, 32'd0, st);
    check("lw_mem_en_masked", 64'(reg_write_enable_MEM), 64'd0);
    check("lw_req_addr", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b0, 32'h0000_0100}));
    wait_idle(20);
    check("lw_req_cycles", 64'(req_cnt), 64'd3);
    check("lw_stall_cycles", 64'(stall_cnt), 64'd2);

    // Load-use: consumer of r4 stalls until the ack clock, then advances.
    ack_lat = 3; rd_val = 32'hCAFE_F00D;
    exp_mem_q.push_back({1'b0, 32'h0000_0104, 32'd0});
    exp_wb_q.push_back({5'd4, 32'hCAFE_F00D});
    exp_wb_q.push_back({5'd5, 32'h0000_0007});
    issue(OP_LW, 5'd4, 1'b1, 5'd0, 5'd0, 32'h0000_0104, 32'd0, st);
    issue(OP_ADD, 5'd5, 1'b1, 5'd0, 5'd4, 32'h0000_0007, 32'd0, st);
    check("loaduse_stall_cycles", 64'(st), 64'd2);
    check("loaduse_fsm_idle", 64'(dbg_state), 64'd0);
    check("loaduse_wb_handoff", 64'({reg_write_enable_WB, reg_write_address_WB, reg_write_data}),
          64'({1'b1, 5'd4, 32'hCAFE_F00D}));
    check("loaduse_mem_stage", 64'({reg_write_enable_MEM, reg_write_address_MEM, alu_result_MEM}),
          64'({1'b1, 5'd5, 32'h0000_0007}));
    @(posedge clk); #1;

    // SW 0x12345678 @0x40, ack in one cycle, no register write.
    ack_lat = 1;
    exp_mem_q.push_back({1'b1, 32'h0000_0040, 32'h1234_5678});
    issue(OP_SW, 5'd7, 1'b1, 5'd1, 5'd2, 32'h0000_0040, 32'h1234_5678, st);
    check("sw_port", 64'({mem_req, mem_we, reg_write_enable_MEM, mem_wdata}),
          64'({1'b1, 1'b1, 1'b0, 32'h1234_5678}));
    wait_idle(20);
    check("sw_wb_en", 64'(reg_write_enable_WB), 64'd0);

    // Back-to-back SW -> LW -> SUB with zero-bubble handoff.
    ack_lat = 2; rd_val = 32'h1111_2222;
    exp_mem_q.push_back({1'b1, 32'h0000_0080, 32'h0000_A5A5});
    exp_mem_q.push_back({1'b0, 32'h0000_0084, 32'd0});
    exp_wb_q.push_back({5'd6, 32'h1111_2222});
    exp_wb_q.push_back({5'd7, 32'hFFFF_FFFE});
    issue(OP_SW, 5'd0, 1'b0, 5'd1, 5'd2, 32'h0000_0080, 32'h0000_A5A5, st);
    issue(OP_LW, 5'd6, 1'b1, 5'd1, 5'd0, 32'h0000_0084, 32'd0, st);
    check("b2b_lw_stalls", 64'(st), 64'd1);
    issue(OP_SUB, 5'd7, 1'b1, 5'd1, 5'd2, 32'hFFFF_FFFE, 32'd0, st);
    check("b2b_sub_stalls", 64'(st), 64'd1);
    repeat (2) @(posedge clk);

    // LW to r0 accesses memory but never writes back.
    ack_lat = 1; rd_val = 32'h5555_AAAA;
    exp_mem_q.push_back({1'b0, 32'h0000_0200, 32'd0});
    issue(OP_LW, 5'd0, 1'b1, 5'd1, 5'd0, 32'h0000_0200, 32'd0, st);
    wait_idle(20);
    repeat (2) @(posedge clk);

    // Memory never acknowledges.
    no_ack = 1'b1;
`ifdef MEM_TIMEOUT_EN
    stall_cnt = 0; req_cnt = 0;
    issue(OP_LW, 5'd6, 1'b1, 5'd0, 5'd0, 32'h0000_0500, 32'd0, st);
    wait_idle(TMO + 10);
    check("tmo_req_cycles", 64'(req_cnt), 64'(TMO));
    check("tmo_error_set", 64'(mem_error), 64'd1);
    check("tmo_stall_released", 64'(stall_EX), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("tmo_error_sticky", 64'(mem_error), 64'd1);
    issue(OP_LW, 5'd8, 1'b1, 5'd0, 5'd0, 32'h0000_0300, 32'd0, st);
    repeat (2) @(posedge clk);
    #1;
`else
    issue(OP_LW, 5'd8, 1'b1, 5'd0, 5'd0, 32'h0000_0300, 32'd0, st);
    repeat (20) @(posedge clk);
    #1;
    check("noack_still_access", 64'({dbg_state, stall_EX, mem_req}), 64'({1'b1, 1'b1, 1'b1}));
    check("noack_no_error", 64'(mem_error), 64'd0);
`endif

    // Reset in the middle of ACCESS clears everything at once.
    check("pre_reset_access", 64'(dbg_state), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_mem_stage", 64'({reg_write_enable_MEM, reg_write_address_MEM, alu_result_MEM}), 64'd0);
    check("midreset_mem_port", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'd0);
    check("midreset_ctrl", 64'({stall_EX, mem_error, dbg_state, reg_write_enable_WB}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_ack = 1'b0;

    // Recovery after reset.
    exp_wb_q.push_back({5'd2, 32'h0000_0042});
    issue(OP_ADD, 5'd2, 1'b1, 5'd1, 5'd1, 32'h0000_0042, 32'd0, st);
    check("post_reset_mem_stage", 64'({reg_write_enable_MEM, reg_write_address_MEM, alu_result_MEM}),
          64'({1'b1, 5'd2, 32'h0000_0042}));
    repeat (3) @(posedge clk);
    #1;

    check("wb_queue_drained", 64'(exp_wb_q.size()), 64'd0);
    check("mem_queue_drained", 64'(exp_mem_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
